// File: rtl/controller_modulo_if.sv
// Control bus between the modulo sequencer and its surroundings.
// Carries the start/busy/done/error handshake, the iteration count and
// every datapath strobe/select. The abort input exists only when
// MODULO_ABORT_EN is defined.
interface controller_modulo_if;
  logic        start;
  logic        valid;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] iter_cnt;
  logic [2:0]  alu_mode;
  logic        wren_update_zahlen;
  logic        wren_zahl1_to_erg;
  logic        wren_res_to_erg;
  logic        wren_term_erg;
  logic        erg_to_alu_a;
  logic        zahl2_to_alu_b;
  logic        check_for_termination;
`ifdef MODULO_ABORT_EN
  logic        abort;
`endif

  // Sequencer side.
  modport master (
`ifdef MODULO_ABORT_EN
    input  abort,
`endif
    input  start, valid,
    output busy, done, error, iter_cnt, alu_mode,
    output wren_update_zahlen, wren_zahl1_to_erg, wren_res_to_erg, wren_term_erg,
    output erg_to_alu_a, zahl2_to_alu_b, check_for_termination
  );

  // Host and datapath side.
  modport slave (
`ifdef MODULO_ABORT_EN
    output abort,
`endif
    output start, valid,
    input  busy, done, error, iter_cnt, alu_mode,
    input  wren_update_zahlen, wren_zahl1_to_erg, wren_res_to_erg, wren_term_erg,
    input  erg_to_alu_a, zahl2_to_alu_b, check_for_termination
  );
endinterface

// File: rtl/controller_modulo.sv
// Sequencer for datapath_modulo: Zahl1 mod Zahl2 by repeated
// compare (a < b) and subtract (a - b), with an iteration watchdog.
// Optional feature macro: MODULO_ABORT_EN (adds bus.abort, which forces
// ERR from any working state).
module controller_modulo #(
  parameter int          ALU_LAT      = 2,
  parameter logic [2:0]  ALU_MODE_SUB = 3'd1,
  parameter logic [2:0]  ALU_MODE_LT  = 3'd2,
  parameter logic [15:0] MAX_ITER     = 16'd65535
) (
  input logic                 clk,
  input logic                 rst_ni,
  controller_modulo_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_CMP, S_CMP_WB,
    S_CHECK, S_SUB, S_SUB_WB, S_DONE, S_ERR
  } state_t;

  // All registered outputs, decoded together from the state being entered.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] alu_mode;
    logic       wren_update_zahlen;
    logic       wren_zahl1_to_erg;
    logic       wren_res_to_erg;
    logic       wren_term_erg;
    logic       erg_to_alu_a;
    logic       zahl2_to_alu_b;
    logic       check_for_termination;
  } ctrl_t;

  localparam int                WAIT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALU_LAT - 1);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       iter_cnt;
  ctrl_t             ctrl_q;

  // Moore decode of a state into its strobe set.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    unique case (s)
      S_LOAD:   c.wren_update_zahlen = 1'b1;
      S_INIT:   c.wren_zahl1_to_erg  = 1'b1;
      S_CMP: begin
        c.alu_mode       = ALU_MODE_LT;
        c.erg_to_alu_a   = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
      end
      S_CMP_WB: begin
        c.alu_mode       = ALU_MODE_LT;
        c.erg_to_alu_a   = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
        c.wren_term_erg  = 1'b1;
      end
      S_CHECK:  c.check_for_termination = 1'b1;
      S_SUB: begin
        c.alu_mode       = ALU_MODE_SUB;
        c.erg_to_alu_a   = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
      end
      S_SUB_WB: begin
        c.alu_mode        = ALU_MODE_SUB;
        c.erg_to_alu_a    = 1'b1;
        c.zahl2_to_alu_b  = 1'b1;
        c.wren_res_to_erg = 1'b1;
      end
      S_DONE:   c.done  = 1'b1;
      S_ERR:    c.error = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_next = S_LOAD;
      S_LOAD:   state_next = S_INIT;
      S_INIT:   state_next = S_CMP;
      S_CMP:    if (wait_cnt == WAIT_LAST) state_next = S_CMP_WB;
      S_CMP_WB: state_next = S_CHECK;
      S_CHECK: begin
        if (bus.valid)                 state_next = S_DONE;
        else if (iter_cnt == MAX_ITER) state_next = S_ERR;
        else                           state_next = S_SUB;
      end
      S_SUB:    if (wait_cnt == WAIT_LAST) state_next = S_SUB_WB;
      S_SUB_WB: state_next = S_CMP;
      S_DONE:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
`ifdef MODULO_ABORT_EN
    if (bus.abort && (state inside {S_LOAD, S_INIT, S_CMP, S_CMP_WB,
                                    S_CHECK, S_SUB, S_SUB_WB})) begin
      state_next = S_ERR;
    end
`endif
  end

  // State, ALU wait counter, iteration counter and registered outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      iter_cnt <= '0;
      ctrl_q   <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so every register sees pre-edge values.
      state  <= state_next;
      ctrl_q <= decode(state_next);

      if ((state == S_CMP || state == S_SUB) && state_next == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if (state == S_LOAD)
        iter_cnt <= '0;
      else if (state == S_SUB_WB && state_next == S_CMP && iter_cnt != MAX_ITER)
        iter_cnt <= iter_cnt + 16'd1;
    end
  end

  assign bus.busy                  = ctrl_q.busy;
  assign bus.done                  = ctrl_q.done;
  assign bus.error                 = ctrl_q.error;
  assign bus.iter_cnt              = iter_cnt;
  assign bus.alu_mode              = ctrl_q.alu_mode;
  assign bus.wren_update_zahlen    = ctrl_q.wren_update_zahlen;
  assign bus.wren_zahl1_to_erg     = ctrl_q.wren_zahl1_to_erg;
  assign bus.wren_res_to_erg       = ctrl_q.wren_res_to_erg;
  assign bus.wren_term_erg         = ctrl_q.wren_term_erg;
  assign bus.erg_to_alu_a          = ctrl_q.erg_to_alu_a;
  assign bus.zahl2_to_alu_b        = ctrl_q.zahl2_to_alu_b;
  assign bus.check_for_termination = ctrl_q.check_for_termination;

endmodule
